// File: rtl/lut_m_pkg.sv
// -----------------------------------------------------------------------------
// lut_m_pkg
// Shared definitions for the memory-mode LUT configuration loader.
//   lut_m_state_e : loader FSM states (IDLE, SHIFT, COMMIT)
//   LUT_M_CNT_W   : width of the accepted-bit counter for a given INPUTS.
//                   One extra bit so the counter can represent MEM_SIZE itself.
// -----------------------------------------------------------------------------
package lut_m_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } lut_m_state_e;

    function automatic int LUT_M_CNT_W(input int inputs);
        return inputs + 1;
    endfunction

endpackage

// File: rtl/lut_m_shiftreg.sv
// -----------------------------------------------------------------------------
// lut_m_shiftreg
// WIDTH-bit right-shifting register. Each enabled cycle the new bit enters the
// MSB and everything moves one place toward bit 0, so after WIDTH shifts the
// first bit shifted in sits in bit 0.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset (register -> 0)
//   i_clr      : synchronous clear (highest priority after reset)
//   i_shift_en : shift one position this cycle
//   i_bit      : bit entering the MSB
//   o_q        : register contents
// -----------------------------------------------------------------------------
module lut_m_shiftreg
    import lut_m_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_shift_en,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Shift register state: reset, clear, shift, or hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= {WIDTH{1'b0}};
        end else if (i_clr) begin
            r_q <= {WIDTH{1'b0}};
        end else if (i_shift_en) begin
            r_q <= {i_bit, r_q[WIDTH-1:1]};
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/lut_m_loader.sv
// -----------------------------------------------------------------------------
// lut_m_loader
// Configuration / write sequencer for one memory-mode LUT.
//   - Bulk load: after load_start, accepts MEM_SIZE serial bits on a
//     valid/ready handshake, then pulses config_en/load_done for one cycle.
//     The first accepted bit lands in config_in[0].
//   - Single-bit writes: accepted only while idle; each accepted request
//     appears on waddr/data_in with write_en high for exactly one cycle.
// Ports:
//   config_clk, config_rst_n : clock and asynchronous active-low reset
//   load_start               : request a bulk load (honoured in IDLE only)
//   bit_in/bit_valid/bit_ready : serial configuration stream
//   wr_valid/wr_addr/wr_data/wr_ready : single-bit write request
//   config_en, config_in     : commit strobe and assembled word to the LUT
//   waddr, data_in, write_en : LUT single-bit write port
//   load_done                : bulk load committed (same cycle as config_en)
// All handshake-facing outputs are registered.
// -----------------------------------------------------------------------------
module lut_m_loader
    import lut_m_pkg::*;
#(
    parameter int INPUTS   = 4,
    parameter int MEM_SIZE = 2 ** INPUTS
) (
    input  logic                config_clk,
    input  logic                config_rst_n,
    input  logic                load_start,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic                bit_ready,
    input  logic                wr_valid,
    input  logic [INPUTS-1:0]   wr_addr,
    input  logic                wr_data,
    output logic                wr_ready,
    output logic                config_en,
    output logic [MEM_SIZE-1:0] config_in,
    output logic [INPUTS-1:0]   waddr,
    output logic                data_in,
    output logic                write_en,
    output logic                load_done
);

    localparam int CNT_W = LUT_M_CNT_W(INPUTS);

    lut_m_state_e      r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_bit_ready;
    logic              r_wr_ready;
    logic              r_config_en;
    logic              r_load_done;
    logic [INPUTS-1:0] r_waddr;
    logic              r_data_in;
    logic              r_write_en;

    logic              w_bit_hs;
    logic              w_wr_hs;
    logic              w_last_bit;
    logic              w_bad_state;
    logic [MEM_SIZE-1:0] w_shift_q;

    // Ready flags are registered and only ever high in the matching state,
    // so the handshakes need no extra state qualification.
    assign w_bit_hs   = bit_valid & r_bit_ready;
    assign w_wr_hs    = wr_valid & r_wr_ready;
    assign w_last_bit = (r_cnt == CNT_W'(MEM_SIZE - 1));

    // A corrupted state encoding means the partial word cannot be trusted;
    // the FSM recovers to IDLE and the shift register is wiped alongside.
    assign w_bad_state = (r_state != IDLE) && (r_state != SHIFT) && (r_state != COMMIT);

    lut_m_shiftreg #(
        .WIDTH (MEM_SIZE)
    ) u_shiftreg (
        .i_clk      (config_clk),
        .i_rst_n    (config_rst_n),
        .i_clr      (w_bad_state),
        .i_shift_en (w_bit_hs),
        .i_bit      (bit_in),
        .o_q        (w_shift_q)
    );

    // Loader FSM with bit counter and registered Moore outputs.
    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_bit_ready <= 1'b0;
            r_wr_ready  <= 1'b0;
            r_config_en <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            // Commit strobes are single-cycle unless re-asserted below.
            r_config_en <= 1'b0;
            r_load_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load_start) begin
                        r_state     <= SHIFT;
                        r_cnt       <= {CNT_W{1'b0}};
                        r_bit_ready <= 1'b1;
                        r_wr_ready  <= 1'b0;
                    end else begin
                        r_state     <= IDLE;
                        r_bit_ready <= 1'b0;
                        r_wr_ready  <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_wr_ready <= 1'b0;
                    if (w_bit_hs) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last_bit) begin
                            r_state     <= COMMIT;
                            r_bit_ready <= 1'b0;
                            r_config_en <= 1'b1;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state     <= SHIFT;
                            r_bit_ready <= 1'b1;
                        end
                    end else begin
                        r_state     <= SHIFT;
                        r_bit_ready <= 1'b1;
                    end
                end
                COMMIT: begin
                    r_state     <= IDLE;
                    r_bit_ready <= 1'b0;
                    r_wr_ready  <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= {CNT_W{1'b0}};
                    r_bit_ready <= 1'b0;
                    r_wr_ready  <= 1'b0;
                end
            endcase
        end
    end

    // Single-bit write port: capture on handshake, strobe for one cycle.
    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            r_waddr    <= {INPUTS{1'b0}};
            r_data_in  <= 1'b0;
            r_write_en <= 1'b0;
        end else if (w_wr_hs) begin
            r_waddr    <= wr_addr;
            r_data_in  <= wr_data;
            r_write_en <= 1'b1;
        end else begin
            r_waddr    <= r_waddr;
            r_data_in  <= r_data_in;
            r_write_en <= 1'b0;
        end
    end

    assign bit_ready = r_bit_ready;
    assign wr_ready  = r_wr_ready;
    assign config_en = r_config_en;
    assign load_done = r_load_done;
    assign config_in = w_shift_q;
    assign waddr     = r_waddr;
    assign data_in   = r_data_in;
    assign write_en  = r_write_en;

endmodule

// File: doc/lut_m_loader.md
# lut_m_loader

Configuration and write sequencer that drives one memory LUT (`lut_m`) from the configuration side. It accepts a serial bitstream over a valid/ready handshake, assembles a full `MEM_SIZE`-bit configuration word, and commits it with a one-cycle `config_en` strobe. Between bulk loads it forwards single-bit write requests onto the LUT's `waddr`/`data_in`/`write_en` port. It sits between the fabric configuration chain and each memory-mode LUT.

## Interface
- `INPUTS`, 4, LUT address width.
- `MEM_SIZE`, 2**INPUTS, configuration word width in bits.
- `config_clk`  in  1  sole clock; all state updates on the rising edge.
- `config_rst_n`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  one-cycle request to begin a bulk load.
- `bit_in`  in  1  serial configuration bit.
- `bit_valid`  in  1  `bit_in` is valid.
- `bit_ready`  out  1  loader accepts a bit this cycle.
- `wr_valid`  in  1  single-bit write request valid.
- `wr_addr`  in  INPUTS  write address.
- `wr_data`  in  1  write data.
- `wr_ready`  out  1  write request accepted this cycle.
- `config_en`  out  1  commit strobe to the LUT.
- `config_in`  out  MEM_SIZE  assembled configuration word.
- `waddr`  out  INPUTS  LUT write address.
- `data_in`  out  1  LUT write data.
- `write_en`  out  1  LUT single-bit write strobe.
- `load_done`  out  1  bulk load committed.

## Operation
- FSM states: IDLE, SHIFT, COMMIT. Reset state is IDLE.
- IDLE:
  - `wr_ready`=1 and `bit_ready`=0.
  - On `load_start`, go to SHIFT and clear the bit counter.
  - If `wr_valid` and `load_start` occur in the same cycle, both are accepted: the write issues and the FSM enters SHIFT. The later commit overwrites that write.
- SHIFT:
  - `bit_ready`=1 and `wr_ready`=0.
  - Each handshake (`bit_valid`&`bit_ready`) shifts `bit_in` into the MSB of the shift register and shifts the register right.
  - The first bit accepted ends up in `config_in[0]`.
  - The counter is INPUTS+1 bits wide and counts accepted bits.
  - On the handshake of bit number MEM_SIZE, go to COMMIT.
  - `load_start` is ignored in this state.
- COMMIT:
  - Lasts exactly one cycle: `config_en`=1 and `load_done`=1. Both are Moore outputs.
  - `wr_ready`=0 and `bit_ready`=0.
  - Next state is IDLE unconditionally.
- Write path: a handshake (`wr_valid`&`wr_ready`) registers `wr_addr`→`waddr` and `wr_data`→`data_in`, and sets `write_en`=1 for exactly the next cycle.
- `config_in` is driven directly from the shift register. It holds its value after commit until the next load shifts new bits in.
- Reset asserted mid-load discards the partial word. No `config_en` is issued.

## Timing
- Reset values: `config_in`=0, `waddr`=0, `data_in`=0, `write_en`=0, `config_en`=0, `load_done`=0, `bit_ready`=0, `wr_ready`=0 while reset is held. `wr_ready` goes to 1 in the first IDLE cycle after reset release.
- Write latency: handshake on cycle N gives `write_en`=1 on cycle N+1. Back-to-back writes give `write_en` high on consecutive cycles.
- Bulk load with `bit_valid` held high:
  - `load_start` on cycle 0.
  - Bits accepted on cycles 1..MEM_SIZE.
  - `config_en`/`load_done` on cycle MEM_SIZE+1.
  - `wr_ready`=1 on cycle MEM_SIZE+2.
- Bubbles on `bit_valid` stall the counter and the shift register. There is no timeout.

## Structure
- Package `lut_m_pkg` holds the FSM state enum (IDLE, SHIFT, COMMIT) and a `LUT_M_CNT_W(INPUTS)` width helper.
- One sub-module, `lut_m_shiftreg`: a MEM_SIZE-wide right-shifting register with shift-enable and synchronous clear. Its counter stays in the top-level FSM.

## Test plan
- Reset release: all outputs are 0, then `wr_ready`=1 the next cycle.
- Single write: `wr_addr`=5, `wr_data`=1 accepted on cycle N → cycle N+1 shows `write_en`=1, `waddr`=5, `data_in`=1, and `write_en`=0 on N+2.
- Bulk load, MEM_SIZE=16: bits 1,0,0,… with the first bit=1 and the last bit=1 → `config_in`=16'h8001, and `config_en`/`load_done` high for exactly one cycle at cycle 17.
- Stalled load: `bit_valid` toggles every other cycle → commit occurs only after 16 accepted bits (cycle 33) and the value is unchanged from the unstalled case.
- Simultaneous `load_start`+`wr_valid` in IDLE → `write_en` pulses on the next cycle, the FSM is in SHIFT, and `wr_ready`=0 throughout the load.
- Reset asserted after 7 bits → all outputs 0 immediately, no `config_en`, and a subsequent full load commits only the new 16 bits.
